// File: rtl/mc_datapath_regs_pkg.sv
// Shared constants for the multi-cycle MIPS datapath register bank:
// word width, opcode values and next-PC source encodings.
package mc_datapath_regs_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [1:0] {
    PCSRC_ALU  = 2'b00,
    PCSRC_BTGT = 2'b01,
    PCSRC_JUMP = 2'b10,
    PCSRC_RSVD = 2'b11
  } pcsrc_e;

  // beq takes on zero, bne on non-zero; every other opcode never branches.
  function automatic logic branch_cond(input logic [5:0] opcode, input logic zero);
    logic cond;
    case (opcode)
      OP_BEQ:  cond = zero;
      OP_BNE:  cond = ~zero;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/mc_next_pc.sv
// Combinational branch decision and next-PC source selection.
// The reserved source encoding suppresses the PC write entirely.
module mc_next_pc
  import mc_datapath_regs_pkg::*;
(
  input  logic [1:0]        i_pc_source,
  input  logic              i_pc_write,
  input  logic              i_pc_write_cond,
  input  logic              i_zero,
  input  logic [5:0]        i_opcode,
  input  logic [WORD_W-1:0] i_pc,
  input  logic [WORD_W-1:0] i_alu_result,
  input  logic [WORD_W-1:0] i_btgt,
  input  logic [WORD_W-1:0] i_jump_target,
  output logic              o_pc_we,
  output logic [WORD_W-1:0] o_next_pc
);

  logic w_take;

  // Select the next PC and decide whether the PC register updates this edge.
  always_comb begin
    w_take    = i_pc_write_cond & branch_cond(i_opcode, i_zero);
    o_pc_we   = i_pc_write | w_take;
    o_next_pc = i_pc;
    case (pcsrc_e'(i_pc_source))
      PCSRC_ALU:  o_next_pc = i_alu_result;
      PCSRC_BTGT: o_next_pc = i_btgt;
      PCSRC_JUMP: o_next_pc = i_jump_target;
      default: begin
        o_pc_we   = 1'b0;
        o_next_pc = i_pc;
      end
    endcase
  end

endmodule

// File: rtl/mc_datapath_regs.sv
// Register bank of the multi-cycle MIPS datapath (PC, IR, MDR, A, B, ALUOut, branch target).
// Optional performance counters are built only when MC_PERF_CNT_EN is defined.
module mc_datapath_regs
  import mc_datapath_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcWrite,
  input  logic              pcWriteCond,
  input  logic              IorD,
  input  logic              IRwrite,
  input  logic              MDRWrite,
  input  logic              ALUOutWrite,
  input  logic [1:0]        pcSource,
  input  logic              zero,
  input  logic [WORD_W-1:0] aluResult,
  input  logic [WORD_W-1:0] memRdata,
  input  logic [WORD_W-1:0] rdData1,
  input  logic [WORD_W-1:0] rdData2,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] memAddr,
  output logic [WORD_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [WORD_W-1:0] mdr,
  output logic [WORD_W-1:0] regA,
  output logic [WORD_W-1:0] regB,
  output logic [WORD_W-1:0] aluOut,
  output logic [WORD_W-1:0] jumpTarget,
  output logic [WORD_W-1:0] linkAddr,
  output logic [CNT_W-1:0]  instret,
  output logic [CNT_W-1:0]  cycles
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_mdr;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic [WORD_W-1:0] r_alu_out;
  logic [WORD_W-1:0] r_btgt;
  logic              r_dec;
  logic              w_pc_we;
  logic [WORD_W-1:0] w_next_pc;
  logic [WORD_W-1:0] w_jump_target;

  assign w_jump_target = {r_pc[31:28], r_ir[25:0], 2'b00};

  mc_next_pc u_next_pc (
    .i_pc_source     (pcSource),
    .i_pc_write      (pcWrite),
    .i_pc_write_cond (pcWriteCond),
    .i_zero          (zero),
    .i_opcode        (r_ir[31:26]),
    .i_pc            (r_pc),
    .i_alu_result    (aluResult),
    .i_btgt          (r_btgt),
    .i_jump_target   (w_jump_target),
    .o_pc_we         (w_pc_we),
    .o_next_pc       (w_next_pc)
  );

  // Architectural and inter-cycle registers; the branch target is grabbed in the
  // decode cycle (the edge after IR load) when the ALU is forming PC+(imm<<2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'h0000_0000;
      r_mdr     <= 32'h0000_0000;
      r_a       <= 32'h0000_0000;
      r_b       <= 32'h0000_0000;
      r_alu_out <= 32'h0000_0000;
      r_btgt    <= 32'h0000_0000;
      r_dec     <= 1'b0;
    end else begin
      r_dec <= IRwrite;
      r_a   <= rdData1;
      r_b   <= rdData2;
      if (w_pc_we)     r_pc      <= w_next_pc;
      if (IRwrite)     r_ir      <= memRdata;
      if (MDRWrite)    r_mdr     <= memRdata;
      if (ALUOutWrite) r_alu_out <= aluResult;
      if (r_dec)       r_btgt    <= aluResult;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_instret;

  // Free-running cycle and retired-instruction counters, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles  <= '0;
      r_instret <= '0;
    end else begin
      r_cycles <= r_cycles + CNT_W'(1);
      if (IRwrite) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign cycles  = r_cycles;
  assign instret = r_instret;
`else
  assign cycles  = '0;
  assign instret = '0;
`endif

  assign pc         = r_pc;
  assign memAddr    = IorD ? r_alu_out : r_pc;
  assign ir         = r_ir;
  assign opcode     = r_ir[31:26];
  assign mdr        = r_mdr;
  assign regA       = r_a;
  assign regB       = r_b;
  assign aluOut     = r_alu_out;
  assign jumpTarget = w_jump_target;
  assign linkAddr   = r_pc;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Self-checking bench for mc_datapath_regs: table of control vectors with a
// scoreboard queue, plus an asynchronous mid-instruction reset sequence.
module tb_mc_datapath_regs;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;
  logic pcWrite, pcWriteCond, IorD, IRwrite, MDRWrite, ALUOutWrite, zero;
  logic [1:0]  pcSource;
  logic [31:0] aluResult, memRdata, rdData1, rdData2;
  logic [31:0] pc, memAddr, ir, mdr, regA, regB, aluOut, jumpTarget, linkAddr;
  logic [5:0]  opcode;
  logic [CW-1:0] instret, cycles;

  mc_datapath_regs #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .IorD(IorD), .IRwrite(IRwrite), .MDRWrite(MDRWrite), .ALUOutWrite(ALUOutWrite),
    .pcSource(pcSource), .zero(zero), .aluResult(aluResult), .memRdata(memRdata),
    .rdData1(rdData1), .rdData2(rdData2), .pc(pc), .memAddr(memAddr), .ir(ir),
    .opcode(opcode), .mdr(mdr), .regA(regA), .regB(regB), .aluOut(aluOut),
    .jumpTarget(jumpTarget), .linkAddr(linkAddr), .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pcw, pcwc, iord, irw, mdrw, aluw;
    logic [1:0] psrc;
    logic zero;
    logic [31:0] alu, mrd;
    logic [31:0] e_pc, e_ir, e_mdr, e_alo, e_madr;
  } vec_t;

  typedef struct {
    logic [31:0] pc, ir, mdr, alo, madr, a, b;
  } exp_t;

  vec_t tbl[25];
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] m_cycles, m_instret;

  // Reference counter model (edges out of reset, IR loads).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cycles  <= '0;
      m_instret <= '0;
    end else begin
      m_cycles <= m_cycles + CW'(1);
      if (IRwrite) m_instret <= m_instret + CW'(1);
    end
  end

  function automatic vec_t v(input logic pcw, pcwc, iord, irw, mdrw, aluw,
                             input logic [1:0] psrc, input logic z,
                             input logic [31:0] alu, mrd, e_pc, e_ir, e_mdr, e_alo, e_madr);
    vec_t r;
    r.pcw = pcw; r.pcwc = pcwc; r.iord = iord; r.irw = irw; r.mdrw = mdrw; r.aluw = aluw;
    r.psrc = psrc; r.zero = z; r.alu = alu; r.mrd = mrd;
    r.e_pc = e_pc; r.e_ir = e_ir; r.e_mdr = e_mdr; r.e_alo = e_alo; r.e_madr = e_madr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_cnt();
`ifdef MC_PERF_CNT_EN
    chk("cycles", 32'(cycles), 32'(m_cycles));
    chk("instret", 32'(instret), 32'(m_instret));
`else
    chk("cycles", 32'(cycles), 32'h0000_0000);
    chk("instret", 32'(instret), 32'h0000_0000);
`endif
  endtask

  task automatic step(input int i);
    exp_t e, g;
    logic [31:0] rd1, rd2;
    @(negedge clk);
    rd1 = 32'hA5A5_0000 ^ 32'(i);
    rd2 = 32'h5A5A_0000 ^ 32'(i);
    pcWrite = tbl[i].pcw; pcWriteCond = tbl[i].pcwc; IorD = tbl[i].iord;
    IRwrite = tbl[i].irw; MDRWrite = tbl[i].mdrw; ALUOutWrite = tbl[i].aluw;
    pcSource = tbl[i].psrc; zero = tbl[i].zero; aluResult = tbl[i].alu;
    memRdata = tbl[i].mrd; rdData1 = rd1; rdData2 = rd2;
    e.pc = tbl[i].e_pc; e.ir = tbl[i].e_ir; e.mdr = tbl[i].e_mdr;
    e.alo = tbl[i].e_alo; e.madr = tbl[i].e_madr; e.a = rd1; e.b = rd2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected entry at vector %0d", i);
    end else begin
      g = sb_q.pop_front();
      chk($sformatf("pc[%0d]", i), pc, g.pc);
      chk($sformatf("ir[%0d]", i), ir, g.ir);
      chk($sformatf("opcode[%0d]", i), {26'd0, opcode}, {26'd0, g.ir[31:26]});
      chk($sformatf("mdr[%0d]", i), mdr, g.mdr);
      chk($sformatf("aluOut[%0d]", i), aluOut, g.alo);
      chk($sformatf("memAddr[%0d]", i), memAddr, g.madr);
      chk($sformatf("regA[%0d]", i), regA, g.a);
      chk($sformatf("regB[%0d]", i), regB, g.b);
      chk($sformatf("linkAddr[%0d]", i), linkAddr, g.pc);
      chk($sformatf("jumpTarget[%0d]", i), jumpTarget, {g.pc[31:28], g.ir[25:0], 2'b00});
      chk_cnt();
    end
  endtask

  initial begin
    //            pcw  pcwc iord irw  mdrw aluw psrc  zero  alu           mrd           e_pc          e_ir          e_mdr         e_alo         e_madr
    tbl[0]  = v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,32'h0000_0044,32'h1085_0003,32'h0000_0044,32'h1085_0003,32'h0,32'h0,32'h0000_0044);
    tbl[1]  = v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,32'h0000_0050,32'h0,        32'h0000_0044,32'h1085_0003,32'h0,32'h0,32'h0000_0044);
    tbl[2]  = v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,32'h0000_1234,32'h0,        32'h0000_0044,32'h1085_0003,32'h0,32'h0,32'h0000_0044);
    tbl[3]  = v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b1,32'h0000_1234,32'h0,        32'h0000_0050,32'h1085_0003,32'h0,32'h0,32'h0000_0050);
    tbl[4]  = v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,32'h0000_0054,32'h1400_0002,32'h0000_0054,32'h1400_0002,32'h0,32'h0,32'h0000_0054);
    tbl[5]  = v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,32'h0000_0080,32'h0,        32'h0000_0054,32'h1400_0002,32'h0,32'h0,32'h0000_0054);
    tbl[6]  = v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b1,32'h0,        32'h0,        32'h0000_0054,32'h1400_0002,32'h0,32'h0,32'h0000_0054);
    tbl[7]  = v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,32'h0,        32'h0,        32'h0000_0080,32'h1400_0002,32'h0,32'h0,32'h0000_0080);
    tbl[8]  = v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,32'h0000_0084,32'h0022_1820,32'h0000_0084,32'h0022_1820,32'h0,32'h0,32'h0000_0084);
    tbl[9]  = v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,32'h0000_0200,32'h0,        32'h0000_0084,32'h0022_1820,32'h0,32'h0,32'h0000_0084);
    tbl[10] = v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b1,32'h0,        32'h0,        32'h0000_0084,32'h0022_1820,32'h0,32'h0,32'h0000_0084);
    tbl[11] = v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,32'h0,        32'h0,        32'h0000_0084,32'h0022_1820,32'h0,32'h0,32'h0000_0084);
    tbl[12] = v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,32'h0000_0999,32'h0,        32'h0000_0084,32'h0022_1820,32'h0,32'h0,32'h0000_0084);
    tbl[13] = v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,32'h0000_0088,32'h0,        32'h0000_0088,32'h0022_1820,32'h0,32'h0,32'h0000_0088);
    tbl[14] = v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,32'h4000_0004,32'h0800_0010,32'h4000_0004,32'h0800_0010,32'h0,32'h0,32'h4000_0004);
    tbl[15] = v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,        32'h0,        32'h4000_0004,32'h0800_0010,32'h0,32'h0,32'h4000_0004);
    tbl[16] = v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,1'b0,32'h0,        32'h0,        32'h4000_0040,32'h0800_0010,32'h0,32'h0,32'h4000_0040);
    tbl[17] = v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,32'h0000_0100,32'h0,        32'h4000_0040,32'h0800_0010,32'h0,32'h0000_0100,32'h4000_0040);
    tbl[18] = v(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,32'h0,        32'hDEAD_BEEF,32'h4000_0040,32'h0800_0010,32'hDEAD_BEEF,32'h0000_0100,32'h0000_0100);
    tbl[19] = v(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'd0,1'b0,32'h0000_0104,32'h1111_1111,32'h4000_0040,32'h0800_0010,32'hDEAD_BEEF,32'h0000_0104,32'h0000_0104);
    tbl[20] = v(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,32'h0000_0022,32'h1000_0003,32'h0000_0022,32'h1000_0003,32'hDEAD_BEEF,32'h0000_0104,32'h0000_0104);
    // after the asynchronous reset: branch target and decode flag must both be clear
    tbl[21] = v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,32'h0000_0777,32'h0,        32'h0,        32'h0,        32'h0,32'h0,32'h0);
    tbl[22] = v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,32'h0,32'h0);
    tbl[23] = v(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,32'h0000_0004,32'h0800_0010,32'h0000_0004,32'h0800_0010,32'h0,32'h0,32'h0000_0004);
    tbl[24] = v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,1'b0,32'h0,        32'h0,        32'h0000_0040,32'h0800_0010,32'h0,32'h0,32'h0000_0040);

    reset = 1'b1;
    pcWrite = 1'b0; pcWriteCond = 1'b0; IorD = 1'b0; IRwrite = 1'b0; MDRWrite = 1'b0;
    ALUOutWrite = 1'b0; pcSource = 2'd0; zero = 1'b0; aluResult = 32'h0;
    memRdata = 32'h0; rdData1 = 32'h0; rdData2 = 32'h0;
    #3;
    reset = 1'b0;
    #1;
    chk("reset_pc", pc, 32'h0000_0040);
    chk("reset_memAddr", memAddr, 32'h0000_0040);
    chk("reset_ir", ir, 32'h0);
    chk_cnt();

    for (int i = 0; i <= 20; i++) step(i);

    // Asynchronous reset mid-instruction, right after an IR load (decode flag set).
    reset = 1'b1;
    #1;
    chk("mid_reset_pc", pc, 32'h0000_0040);
    chk("mid_reset_ir", ir, 32'h0);
    chk("mid_reset_mdr", mdr, 32'h0);
    chk("mid_reset_regA", regA, 32'h0);
    chk("mid_reset_regB", regB, 32'h0);
    chk("mid_reset_aluOut", aluOut, 32'h0);
    chk("mid_reset_memAddr", memAddr, 32'h0);
    chk_cnt();
    #1;
    reset = 1'b0;

    for (int i = 21; i <= 24; i++) step(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_datapath_regs.md
Name: mc_datapath_regs

Overview:
- Architectural and inter-cycle register bank of the multi-cycle MIPS datapath. It sits directly downstream of the multi-cycle control FSM and consumes its per-state strobes.
- Holds PC, IR, MDR, A, B, ALUOut and a captured branch-target register.
- Generates the memory address, the next-PC selection (including the beq/bne condition) and the jump/link values fed back to the ALU, memory and register file.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcWrite  in  1  unconditional PC write strobe from the FSM.
- pcWriteCond  in  1  conditional PC write strobe (branch).
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- IRwrite  in  1  instruction register load.
- MDRWrite  in  1  memory data register load.
- ALUOutWrite  in  1  ALUOut register load.
- pcSource  in  2  next-PC source select.
- zero  in  1  ALU zero flag.
- aluResult  in  32  combinational ALU output.
- memRdata  in  32  memory read data (asynchronous read, valid in the same cycle).
- rdData1  in  32  register file read port 1.
- rdData2  in  32  register file read port 2.
- pc  out  32  current PC.
- memAddr  out  32  memory address.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26].
- mdr  out  32  memory data register.
- regA  out  32  A register.
- regB  out  32  B register (also the store data).
- aluOut  out  32  ALUOut register.
- jumpTarget  out  32  {pc[31:28], ir[25:0], 2'b00}.
- linkAddr  out  32  return address for jal; equals pc.
- instret  out  CNT_W  retired-instruction count.
- cycles  out  CNT_W  cycle count.

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction):
  - pc = RESET_PC.
  - ir, mdr, regA, regB, aluOut, branch target and decode flag = 0.
  - Counters = 0.
  - Outputs follow within the same delta; the first edge after release behaves as a fetch cycle.
- IR: on a clk edge with IRwrite=1, ir <= memRdata. Otherwise it holds.
- Decode flag dec:
  - dec <= IRwrite on every edge.
  - On an edge where dec=1, btgt <= aluResult. This captures PC+(imm<<2), which the FSM computes in the decode cycle without asserting ALUOutWrite.
- regA/regB: load rdData1/rdData2 on every edge (no enable).
- mdr: loads memRdata when MDRWrite=1.
- aluOut: loads aluResult when ALUOutWrite=1.
- memAddr: combinational; IorD ? aluOut : pc.
- Branch condition:
  - take = pcWriteCond & ((opcode==6'b000100) ? zero : (opcode==6'b000101) ? ~zero : 0).
  - Other opcodes never take.
- PC update on an edge when (pcWrite | take):
  - pcSource 00: aluResult (PC+4 in fetch).
  - pcSource 01: btgt.
  - pcSource 10: jumpTarget.
  - pcSource 11: reserved; PC holds even if strobed.
- Simultaneous pcWrite and pcWriteCond: an unconditional write; take is ignored.
- IRwrite and pcWrite in the same cycle: ir captures the instruction at the old pc; pc updates to the new value. No hazard.
- Arithmetic:
  - No adder inside the block; all sums come from aluResult.
  - jumpTarget uses the already-incremented pc.
  - Widths are exact; no wrap handling beyond natural 32-bit truncation in the ALU.
- Latency: every register is visible on outputs one cycle after its enabled edge.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - cycles increments every edge out of reset.
  - instret increments on each edge with IRwrite=1.
  - Both wrap modulo 2^CNT_W.
- Undefined: instret and cycles are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_LHU, OP_SLTIU, OP_BEQ, OP_BNE, OP_J, OP_JAL);
  - pcSource encodings (PCSRC_ALU=0, PCSRC_BTGT=1, PCSRC_JUMP=2);
  - the 32-bit word width constant.
- One natural sub-module, mc_next_pc: the combinational branch-condition and next-PC selection logic. All registers stay in the parent.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, then release -> pc=0x40, memAddr=0x40, ir=0.
- IRwrite=1, pcWrite=1, pcSource=00, memRdata=0x1085_0003, aluResult=0x44 -> ir=0x10850003, pc=0x44. Next edge with aluResult=0x50 -> btgt=0x50.
- beq: pcWriteCond=1, pcSource=01, zero=1 -> pc=0x50. Repeat with zero=0 -> pc stays 0x44.
- bne (opcode 000101), zero=0 -> taken. Opcode 000000 with pcWriteCond=1 -> not taken.
- j with ir=0x0800_0010, pc=0x4000_0004, pcSource=10, pcWrite=1 -> pc=0x4000_0040. linkAddr before the jump = 0x4000_0004.
- Load path: ALUOutWrite with aluResult=0x100, then IorD=1 -> memAddr=0x100. MDRWrite with memRdata=0xDEAD_BEEF -> mdr=0xDEADBEEF. Assert reset mid-sequence -> all registers cleared asynchronously; with MC_PERF_CNT_EN, instret=0.
